// File: rtl/pifo_pop_ctrl.sv
// Dequeue-side controller for a priority PIFO: issues credit-limited pops, captures the
// one-cycle-delayed priority_out into a small circular buffer and streams it out valid/ready.
module pifo_pop_ctrl #(
    parameter int DATA_W    = 4,
    parameter int BUF_DEPTH = 4,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              pifo_empty,
    input  logic              pifo_push,
    input  logic [DATA_W-1:0] pifo_data,
    output logic              pifo_pop,
    output logic              m_valid,
    output logic [DATA_W-1:0] m_data,
    input  logic              m_ready,
    output logic              busy,
    output logic [CNT_W-1:0]  pop_cnt
);

    localparam int PTR_W = $clog2(BUF_DEPTH);

    typedef enum logic [1:0] {
        ST_STOPPED,
        ST_RUNNING,
        ST_DRAINING
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_busy;
    logic                r_inflight;
    logic [PTR_W:0]      r_occ;
    logic [PTR_W-1:0]    r_rd_ptr;
    logic [PTR_W-1:0]    r_wr_ptr;
    logic [DATA_W-1:0]   r_mem [BUF_DEPTH];
    logic [CNT_W-1:0]    r_pop_cnt;

    logic [PTR_W+1:0]    w_outstanding;
    logic                w_credit;
    logic                w_rd;
    logic                w_wr;

    // Entries already landed plus the one still on the PIFO output; a same-cycle read is not credited.
    assign w_outstanding = (PTR_W+2)'(r_occ) + (PTR_W+2)'(r_inflight);
    assign w_credit      = w_outstanding < (PTR_W+2)'(BUF_DEPTH);

    assign pifo_pop = (r_state == ST_RUNNING) & enable & ~pifo_empty & ~pifo_push & w_credit;
    assign m_valid  = (r_occ != '0);
    assign m_data   = m_valid ? r_mem[r_rd_ptr] : '0;
    assign w_rd     = m_valid & m_ready;
    assign w_wr     = r_inflight;
    assign busy     = r_busy;
    assign pop_cnt  = r_pop_cnt;

    // NOTE: every signal driven here gets a default before the case so no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_STOPPED:  if (enable) w_state_nxt = ST_RUNNING;
            ST_RUNNING:  if (!enable) w_state_nxt = ST_DRAINING;
            ST_DRAINING: begin
                if (enable)
                    w_state_nxt = ST_RUNNING;
                else if (!r_inflight && (r_occ == '0))
                    w_state_nxt = ST_STOPPED;
            end
            default:     w_state_nxt = ST_STOPPED;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_STOPPED;
            r_busy     <= 1'b0;
            r_inflight <= 1'b0;
            r_occ      <= '0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_pop_cnt  <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_busy     <= (w_state_nxt != ST_STOPPED);
            r_inflight <= pifo_pop;
            if (pifo_pop)
                r_pop_cnt <= r_pop_cnt + CNT_W'(1);
            if (w_wr)
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_rd)
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            unique case ({w_wr, w_rd})
                2'b10:   r_occ <= r_occ + (PTR_W+1)'(1);
                2'b01:   r_occ <= r_occ - (PTR_W+1)'(1);
                default: r_occ <= r_occ;
            endcase
        end
    end

    // NOTE: the storage array has no reset; m_data is masked to zero whenever the buffer is empty.
    always_ff @(posedge clk) begin
        if (!reset && w_wr)
            r_mem[r_wr_ptr] <= pifo_data;
    end

endmodule

// File: tb/tb_pifo_pop_ctrl.sv
// Self-checking bench for pifo_pop_ctrl: a queue-based PIFO and output-stream model drive
// the DUT and predict every output each cycle; directed scenarios add explicit checks.
module tb_pifo_pop_ctrl;

    localparam int DATA_W = 4;
    localparam int DEPTH  = 4;
    localparam int CNT_W  = 4;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              enable = 1'b0;
    logic              pifo_push = 1'b0;
    logic              m_ready = 1'b0;
    logic              pifo_empty = 1'b1;
    logic [DATA_W-1:0] pifo_data = '0;
    logic [DATA_W-1:0] push_val = '0;
    logic              pifo_pop;
    logic              m_valid;
    logic [DATA_W-1:0] m_data;
    logic              busy;
    logic [CNT_W-1:0]  pop_cnt;

    pifo_pop_ctrl #(.DATA_W(DATA_W), .BUF_DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .enable(enable), .pifo_empty(pifo_empty),
        .pifo_push(pifo_push), .pifo_data(pifo_data), .pifo_pop(pifo_pop),
        .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready), .busy(busy),
        .pop_cnt(pop_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: PIFO contents, entries owed to the output stream, and controller mode.
    int pq[$];
    int exp_buf[$];
    bit pop_prev = 1'b0;
    bit run_m    = 1'b0;
    bit busy_m   = 1'b0;
    int exp_cnt  = 0;

    int n_cmp = 0;
    int n_err = 0;
    int obs_q[$];
    int cyc = 0;
    int first_pop_cyc = -1;
    int first_valid_cyc = -1;

    function automatic bit calc_pop();
        return run_m && enable && !pifo_empty && !pifo_push &&
               ((exp_buf.size() + int'(pop_prev)) < DEPTH);
    endfunction

    function automatic int max_idx();
        int mi = 0;
        for (int i = 1; i < pq.size(); i++)
            if (pq[i] > pq[mi]) mi = i;
        return mi;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            pq.delete();
            exp_buf.delete();
            pop_prev   <= 1'b0;
            run_m      <= 1'b0;
            busy_m     <= 1'b0;
            exp_cnt    <= 0;
            pifo_data  <= '0;
            pifo_empty <= 1'b1;
        end else begin
            pop_prev <= calc_pop();
            run_m    <= enable;
            busy_m   <= enable || (busy_m && !(!run_m && (exp_buf.size() + int'(pop_prev)) == 0));
            if (pifo_push) begin
                pq.push_back(int'(push_val));
            end else if (calc_pop()) begin
                pifo_data <= DATA_W'(pq[max_idx()]);
                pq.delete(max_idx());
                exp_cnt <= exp_cnt + 1;
            end
            pifo_empty <= (pq.size() == 0);
            if (exp_buf.size() != 0 && m_ready)
                void'(exp_buf.pop_front());
            if (pop_prev)
                exp_buf.push_back(int'(pifo_data));
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock cycle: inputs are already set; sample outputs, compare, then advance.
    task automatic tick();
        #1;
        check("pifo_pop", 32'(pifo_pop), 32'(calc_pop()));
        check("m_valid", 32'(m_valid), 32'(exp_buf.size() != 0));
        if (exp_buf.size() != 0)
            check("m_data", 32'(m_data), exp_buf[0]);
        check("busy", 32'(busy), 32'(busy_m));
        check("pop_cnt", 32'(pop_cnt), exp_cnt % (1 << CNT_W));
        if (pifo_push)
            check("push_blocks_pop", 32'(pifo_pop), 0);
        if (first_pop_cyc < 0 && pifo_pop === 1'b1) first_pop_cyc = cyc;
        if (first_valid_cyc < 0 && m_valid === 1'b1) first_valid_cyc = cyc;
        if (m_valid === 1'b1 && m_ready) obs_q.push_back(int'(m_data));
        cyc++;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic push_one(input int v);
        pifo_push = 1'b1;
        push_val  = DATA_W'(v);
        tick();
        pifo_push = 1'b0;
    endtask

    task automatic run_until_idle(input int budget);
        int n = 0;
        while (!(pq.size() == 0 && exp_buf.size() == 0 && !pop_prev) && n < budget) begin
            tick();
            n++;
        end
        check("drain_done", 32'(n < budget), 1);
    endtask

    initial begin
        int exp_order[4] = '{9, 6, 3, 1};
        int pushed[$];
        int c0;
        int n;
        bit found;

        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_pifo_pop", 32'(pifo_pop), 0);
        check("rst_m_valid", 32'(m_valid), 0);
        check("rst_m_data", 32'(m_data), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_pop_cnt", 32'(pop_cnt), 0);

        // Basic priority order and first-entry latency
        push_one(3); push_one(9); push_one(1); push_one(6);
        obs_q.delete();
        first_pop_cyc = -1; first_valid_cyc = -1;
        enable = 1'b1; m_ready = 1'b1;
        run_until_idle(40);
        check("order_len", obs_q.size(), 4);
        for (int i = 0; i < 4 && i < obs_q.size(); i++)
            check($sformatf("order_%0d", i), obs_q[i], exp_order[i]);
        check("first_valid_latency", first_valid_cyc - first_pop_cyc, 2);
        tick(); tick();
        check("basic_pop_cnt", 32'(pop_cnt), 4);
        check("basic_idle_pop", 32'(pifo_pop), 0);
        enable = 1'b0;
        repeat (3) tick();
        check("basic_stopped", 32'(busy), 0);

        // Backpressure: six queued, downstream stalled, only DEPTH pops may go out
        m_ready = 1'b0;
        pushed.delete();
        for (int i = 0; i < 6; i++) begin
            pushed.push_back(int'($urandom_range(0, 15)));
            push_one(pushed[i]);
        end
        pushed.rsort();
        obs_q.delete();
        enable = 1'b1;
        repeat (10) tick();
        check("bp_pops", 32'(pop_cnt), 8);
        check("bp_head", 32'(m_data), pushed[0]);
        check("bp_valid", 32'(m_valid), 1);
        m_ready = 1'b1;
        run_until_idle(40);
        check("bp_delivered", obs_q.size(), 6);
        for (int i = 0; i < 6 && i < obs_q.size(); i++)
            check($sformatf("bp_order_%0d", i), obs_q[i], pushed[i]);
        enable = 1'b0;
        repeat (3) tick();

        // Push collisions on alternating cycles during a drain
        for (int i = 0; i < 4; i++) push_one(int'($urandom_range(0, 10)));
        enable = 1'b1;
        for (int i = 0; i < 16; i++) begin
            pifo_push = (i % 2 == 0);
            push_val  = DATA_W'($urandom_range(0, 15));
            m_ready   = ($urandom_range(0, 3) != 0);
            tick();
        end
        pifo_push = 1'b0;
        m_ready = 1'b1;
        run_until_idle(60);
        enable = 1'b0;
        repeat (3) tick();

        // Drain on disable one cycle after the first pop
        for (int i = 0; i < 4; i++) push_one(int'($urandom_range(0, 15)));
        obs_q.delete();
        c0 = exp_cnt;
        enable = 1'b1;
        tick();
        tick();
        enable = 1'b0;
        tick();
        check("drain_busy_hi", 32'(busy), 1);
        n = 0;
        while (busy_m && n < 20) begin tick(); n++; end
        tick();
        check("drain_busy_lo", 32'(busy), 0);
        check("drain_delivered", obs_q.size(), 1);
        check("drain_pops", 32'(pop_cnt), (c0 + 1) % (1 << CNT_W));
        check("drain_left", pq.size(), 3);
        enable = 1'b1;
        run_until_idle(40);
        enable = 1'b0;
        repeat (3) tick();

        // Reset while one entry is in flight and two are buffered
        for (int i = 0; i < 6; i++) push_one(int'($urandom_range(0, 15)));
        m_ready = 1'b0;
        enable = 1'b1;
        found = 1'b0;
        n = 0;
        while (!found && n < 20) begin
            tick();
            n++;
            found = (exp_buf.size() == 2) && pop_prev;
        end
        check("rst_setup_reached", 32'(found), 1);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("midrst_m_valid", 32'(m_valid), 0);
        check("midrst_pop_cnt", 32'(pop_cnt), 0);
        check("midrst_busy", 32'(busy), 0);
        check("midrst_pifo_pop", 32'(pifo_pop), 0);
        enable = 1'b0;
        m_ready = 1'b1;
        tick();

        // Counter wrap: seventeen pops through a 4-bit counter
        for (int i = 0; i < 17; i++) push_one(int'($urandom_range(0, 15)));
        enable = 1'b1;
        run_until_idle(80);
        tick();
        check("cnt_wrap", 32'(pop_cnt), 1);
        enable = 1'b0;
        repeat (3) tick();

        // Random traffic
        for (int i = 0; i < 300; i++) begin
            enable    = ($urandom_range(0, 7) != 0);
            m_ready   = ($urandom_range(0, 2) != 0);
            pifo_push = ($urandom_range(0, 3) == 0);
            push_val  = DATA_W'($urandom_range(0, 15));
            tick();
        end
        pifo_push = 1'b0;
        enable = 1'b1;
        m_ready = 1'b1;
        run_until_idle(100);
        enable = 1'b0;
        repeat (3) tick();
        check("final_busy", 32'(busy), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
